// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
//   Shared types and constants for the audio playback sequencer.
//   - state_e            : sequencer FSM states
//   - SILENCE            : mid-scale unsigned PCM value (no output swing)
//   - DEFAULT_SAMPLE_DIV : clk cycles per sample at 3.125 MHz (~8.01 kHz)
//   - is_playing()       : true for the states in which the clip is running
// ---------------------------------------------------------------------------
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam logic [7:0] SILENCE            = 8'h80;
  localparam int         DEFAULT_SAMPLE_DIV = 390;

  function automatic logic is_playing(input state_e s);
    return (s == ST_WAIT_TICK) || (s == ST_FETCH);
  endfunction

endpackage

// File: rtl/sample_rate_divider.sv
// ---------------------------------------------------------------------------
// sample_rate_divider
//   Sample-rate timebase. Counts 0..DIV-1 while enabled and flags the last
//   count of each period; sits at 0 whenever it is disabled or cleared.
//
//   clk   in  1  system clock
//   rst   in  1  synchronous reset, active-high
//   clr   in  1  restart the period from 0 on the next cycle
//   en    in  1  count this cycle (0 forces the count back to 0)
//   tick  out 1  high while the count is DIV-1
// ---------------------------------------------------------------------------
module sample_rate_divider
  import audio_pkg::*;
#(
  parameter int DIV = DEFAULT_SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int                 CNT_W   = $clog2(DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default on entry so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded from the register alone; a held counter sits at 0, and DIV >= 2
  // keeps 0 distinct from the terminal count.
  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/audio_playback_sequencer.sv
// ---------------------------------------------------------------------------
// audio_playback_sequencer
//   Turns start/stop commands into paced sample-memory reads and hands each
//   fetched sample to the output stage as a 1-cycle-valid PCM word. Owns the
//   sample timebase, address walk, end-of-clip/loop decision and underrun flag.
//
//   clk        in   1       system clock
//   rst        in   1       synchronous reset, active-high
//   start      in   1       pulse: play from address 0 (ignored while playing)
//   stop       in   1       pulse: abort, return to idle (wins over start)
//   loop_en    in   1       wrap LAST_ADDR -> 0 instead of finishing
//   rd_req     out  1       sample read request
//   rd_addr    out  ADDR_W  sample address, stable while rd_req=1
//   rd_ack     in   1       rd_data valid this cycle
//   rd_data    in   8       unsigned PCM sample
//   pcm_valid  out  1       pulse: pcm_data just updated with a sample
//   pcm_data   out  8       current PCM sample, 8'h80 = silence
//   playing    out  1       clip running (WAIT_TICK/FETCH)
//   done       out  1       clip finished without looping
//   underrun   out  1       sticky: a tick arrived with a fetch outstanding
// ---------------------------------------------------------------------------
module audio_playback_sequencer
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int ADDR_W     = 8,
  parameter int LAST_ADDR  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic              pcm_valid,
  output logic [7:0]        pcm_data,
  output logic              playing,
  output logic              done,
  output logic              underrun
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              pcm_valid_q, pcm_valid_d;
  logic [7:0]        pcm_data_q,  pcm_data_d;
  logic              underrun_q,  underrun_d;

  logic tick;
  logic start_go;

  // A start is only honoured from a stopped state and never alongside stop.
  assign start_go = start && !stop &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // The timebase runs exactly while the next state is a playing state, so it
  // is already at 0 on the first cycle of IDLE/DONE.
  sample_rate_divider #(
    .DIV (SAMPLE_DIV)
  ) u_divider (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_go),
    .en   (is_playing(state_d)),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pcm_valid_d = 1'b0;
    pcm_data_d  = pcm_data_q;
    underrun_d  = underrun_q;

    if (stop) begin
      // Abort from anywhere; the underrun history is deliberately kept.
      state_d    = ST_IDLE;
      pcm_data_d = SILENCE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          // The last sample stays on pcm_data for its valid cycle only.
          pcm_data_d = SILENCE;
          if (start) begin
            state_d    = ST_WAIT_TICK;
            addr_d     = '0;
            underrun_d = 1'b0;
          end
        end

        ST_WAIT_TICK: begin
          if (tick) begin
            state_d = ST_FETCH;
          end
        end

        ST_FETCH: begin
          // A tick here is lost rather than queued; the fetch still finishes.
          if (tick) begin
            underrun_d = 1'b1;
          end
          if (rd_ack) begin
            pcm_valid_d = 1'b1;
            pcm_data_d  = rd_data;
            if (addr_q != LAST) begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_WAIT_TICK;
            end else if (loop_en) begin
              addr_d  = '0;
              state_d = ST_WAIT_TICK;
            end else begin
              state_d = ST_DONE;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pcm_valid_q <= 1'b0;
      pcm_data_q  <= SILENCE;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pcm_valid_q <= pcm_valid_d;
      pcm_data_q  <= pcm_data_d;
      underrun_q  <= underrun_d;
    end
  end

  // Outputs decode straight from registers: no combinational input-to-output path.
  assign rd_req    = (state_q == ST_FETCH);
  assign rd_addr   = addr_q;
  assign pcm_valid = pcm_valid_q;
  assign pcm_data  = pcm_data_q;
  assign playing   = is_playing(state_q);
  assign done      = (state_q == ST_DONE);
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_audio_playback_sequencer.sv
// ---------------------------------------------------------------------------
// tb_audio_playback_sequencer
//   Bench for audio_playback_sequencer with SAMPLE_DIV=4, LAST_ADDR=3 and a
//   memory that returns addr+8'h10 after a programmable number of cycles.
// ---------------------------------------------------------------------------
module tb_audio_playback_sequencer;

  localparam int         DIV   = 4;
  localparam logic [7:0] LAST  = 8'd3;
  localparam int         NVEC  = 22;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop_en;
  logic       rd_req, rd_ack, pcm_valid, playing, done, underrun;
  logic [7:0] rd_addr, rd_data, pcm_data;

  int ack_delay;
  int req_age;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  audio_playback_sequencer #(
    .SAMPLE_DIV (DIV),
    .ADDR_W     (8),
    .LAST_ADDR  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .pcm_valid (pcm_valid),
    .pcm_data  (pcm_data),
    .playing   (playing),
    .done      (done),
    .underrun  (underrun)
  );

  // Sample memory: answers a request once it has been held ack_delay cycles.
  always @(posedge clk) req_age <= rd_req ? req_age + 1 : 0;
  assign rd_ack  = rd_req && (req_age >= ack_delay);
  assign rd_data = rd_addr + 8'h10;

  // ---------------- reference model (cycle arithmetic on playback facts)
  int         m_cyc, m_start_cyc;
  logic       m_active, m_finished, m_fetching, m_valid, m_underrun;
  logic [7:0] m_idx, m_pcm;

  task automatic model_step(input logic i_rst, i_start, i_stop, i_loop, i_ack);
    logic sample_due;
    sample_due = m_active && (((m_cyc - m_start_cyc) % DIV) == DIV - 1);
    m_valid = 1'b0;
    if (i_rst) begin
      m_active = 0; m_finished = 0; m_fetching = 0;
      m_idx = 8'd0; m_pcm = 8'h80; m_underrun = 0;
    end else if (i_stop) begin
      m_active = 0; m_finished = 0; m_fetching = 0; m_pcm = 8'h80;
    end else if (i_start && !m_active) begin
      m_active = 1; m_finished = 0; m_fetching = 0;
      m_idx = 8'd0; m_underrun = 0; m_pcm = 8'h80;
      m_start_cyc = m_cyc + 1;
    end else if (m_active) begin
      if (m_fetching) begin
        if (sample_due) m_underrun = 1;
        if (i_ack) begin
          m_valid = 1; m_pcm = m_idx + 8'h10; m_fetching = 0;
          if (m_idx == LAST) begin
            if (i_loop) m_idx = 8'd0;
            else begin m_active = 0; m_finished = 1; end
          end else begin
            m_idx = m_idx + 8'd1;
          end
        end
      end else if (sample_due) begin
        m_fetching = 1;
      end
    end else if (m_finished) begin
      m_pcm = 8'h80;
    end
    m_cyc++;
  endtask

  function automatic logic [31:0] dut_vec();
    return {11'd0, rd_req, rd_addr, pcm_valid, pcm_data, playing, done, underrun};
  endfunction

  function automatic logic [31:0] model_vec();
    return {11'd0, m_fetching, m_idx, m_valid, m_pcm, m_active, m_finished, m_underrun};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // One clock: model consumes the pre-edge inputs, DUT sampled 1 time unit after.
  task automatic step();
    model_step(rst, start, stop, loop_en, rd_ack);
    @(posedge clk);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic wait_valid(input int budget, output logic got, output logic [7:0] d);
    got = 1'b0; d = 8'h00;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (pcm_valid) begin got = 1'b1; d = pcm_data; end
    end
  endtask

  task automatic wait_req(input int budget, output logic got);
    got = rd_req;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      got = rd_req;
    end
  endtask

  // ---------------- table of cycle vectors for reset and a one-shot clip
  typedef struct {
    logic       rst, start, stop, loop_en;
    logic       req;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] data;
    logic       play, fin, und;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic r, s, p, l, q, input logic [7:0] a,
                              input logic v, input logic [7:0] d, input logic pl, f, u);
    vec_t x;
    x.rst = r; x.start = s; x.stop = p; x.loop_en = l; x.req = q; x.addr = a;
    x.valid = v; x.data = d; x.play = pl; x.fin = f; x.und = u;
    return x;
  endfunction

  logic       got;
  logic [7:0] d, d0;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; ack_delay = 0;
    m_cyc = 0; m_start_cyc = 0; m_active = 0; m_finished = 0; m_fetching = 0;
    m_valid = 0; m_underrun = 0; m_idx = 8'd0; m_pcm = 8'h80;

    //               rst st sp lp  req addr  val data   ply dn un
    tbl[0]  = mk(1, 0, 0, 0,  0, 8'd0, 0, 8'h80, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,  0, 8'd0, 0, 8'h80, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0,  0, 8'd0, 0, 8'h80, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,  0, 8'd0, 0, 8'h80, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,  0, 8'd0, 0, 8'h80, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,  0, 8'd0, 0, 8'h80, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,  1, 8'd0, 0, 8'h80, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,  0, 8'd1, 1, 8'h10, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,  0, 8'd1, 0, 8'h10, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,  0, 8'd1, 0, 8'h10, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0,  1, 8'd1, 0, 8'h10, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0,  0, 8'd2, 1, 8'h11, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,  0, 8'd2, 0, 8'h11, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,  0, 8'd2, 0, 8'h11, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,  1, 8'd2, 0, 8'h11, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, 0,  0, 8'd3, 1, 8'h12, 1, 0, 0);
    tbl[16] = mk(0, 0, 0, 0,  0, 8'd3, 0, 8'h12, 1, 0, 0);
    tbl[17] = mk(0, 0, 0, 0,  0, 8'd3, 0, 8'h12, 1, 0, 0);
    tbl[18] = mk(0, 0, 0, 0,  1, 8'd3, 0, 8'h12, 1, 0, 0);
    tbl[19] = mk(0, 0, 0, 0,  0, 8'd3, 1, 8'h13, 0, 1, 0);
    tbl[20] = mk(0, 0, 0, 0,  0, 8'd3, 0, 8'h80, 0, 1, 0);
    tbl[21] = mk(0, 0, 0, 0,  0, 8'd3, 0, 8'h80, 0, 1, 0);

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop; loop_en = tbl[i].loop_en;
      step();
      check($sformatf("vec%0d", i), dut_vec(),
            {11'd0, tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].data,
             tbl[i].play, tbl[i].fin, tbl[i].und});
    end

    // ---- looping clip restarted from DONE: 10,11,12,13,10,11 and 3 -> 0
    loop_en = 1'b1; start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_valid(20, got, d);
      check("loop_got", {31'd0, got}, 32'd1);
      check($sformatf("loop_data%0d", k), {24'd0, d}, {24'd0, 8'h10 + 8'(k % 4)});
      if (k == 3) check("loop_wrap_addr", {24'd0, rd_addr}, 32'd0);
      check("loop_not_done", {31'd0, done}, 32'd0);
    end

    // ---- stop while rd_req is high
    wait_req(20, got);
    check("stop_req_seen", {31'd0, got}, 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_state", {29'd0, rd_req, playing, done}, 32'd0);
    check("stop_pcm", {24'd0, pcm_data}, 32'h80);

    // ---- start and stop together from IDLE: stop wins
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("startstop_idle", {30'd0, playing, rd_req}, 32'd0);
    for (int k = 0; k < 2 * DIV; k++) step();
    check("startstop_noreq", {30'd0, playing, rd_req}, 32'd0);

    // ---- slow memory: underrun, sample still delivered, sticky across stop
    loop_en = 1'b0; ack_delay = 6;
    start = 1'b1; step(); start = 1'b0;
    wait_valid(30, got, d);
    check("slow_got", {31'd0, got}, 32'd1);
    check("slow_data", {24'd0, d}, 32'h10);
    check("slow_underrun", {31'd0, underrun}, 32'd1);
    wait_req(10, got);
    check("slow_next_req", {31'd0, got}, 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    check("underrun_kept", {31'd0, underrun}, 32'd1);
    start = 1'b1; step(); start = 1'b0;
    check("underrun_cleared", {31'd0, underrun}, 32'd0);

    // ---- start pulse mid-clip is ignored
    ack_delay = 0; loop_en = 1'b1;
    wait_valid(20, got, d0);
    check("mid_got0", {31'd0, got}, 32'd1);
    start = 1'b1; step(); start = 1'b0;
    wait_valid(20, got, d);
    check("mid_got1", {31'd0, got}, 32'd1);
    check("mid_seq", {24'd0, d}, {24'd0, (d0 == 8'h13) ? 8'h10 : d0 + 8'h01});

    // ---- reset in the middle of an outstanding fetch
    ack_delay = 3;
    wait_req(20, got);
    check("rst_req_seen", {31'd0, got}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_mid", dut_vec(), {11'd0, 1'b0, 8'd0, 1'b0, 8'h80, 3'b000});

    // ---- randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      if (!rd_req) ack_delay = $urandom_range(0, 6);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
